safe_entry_ctrl: RTL and testbench

Sequencing controller that sits between the BASYS3 keypad/button debouncers and the digital-safe core. It assembles four hex digits into the 16-bit code presented to the safe and drives the safe's `pass_set`, `pass_reg` and `pass_lock` strobes. It reads back the safe's 2-bit `safestate` to decide among open, set-new-password and failed attempt. After repeated failures it enforces a timed lockout.

---
 rtl/safe_entry_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_safe_entry_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_entry_ctrl.sv
// Keypad sequencing controller for the digital safe: assembles a 4-digit code,
// strobes the safe core, reads back its state and enforces a timed lockout.
module safe_entry_ctrl #(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        clear,
    input  logic        set_req,
    input  logic        lock_req,
    input  logic [1:0]  safestate,
    output logic [15:0] passinput,
    output logic        pass_set,
    output logic        pass_reg,
    output logic        pass_lock,
    output logic [2:0]  digit_cnt,
    output logic [2:0]  fail_cnt,
    output logic        lockout,
    output logic [2:0]  ctrl_state
);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_NEWPASS = 3'd3,
        ST_SAVE    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    localparam logic [2:0]  MAX_FAIL  = 3'(MAX_TRIES);
    localparam logic [31:0] LOCK_LOAD = 32'(LOCKOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] passinput_q, passinput_d;
    logic [2:0]  digit_cnt_q, digit_cnt_d;
    logic [2:0]  fail_cnt_q, fail_cnt_d;
    logic        pass_set_q, pass_set_d;
    logic        pass_reg_q, pass_reg_d;
    logic        pass_lock_q, pass_lock_d;
    logic        lockout_q, lockout_d;
    logic        check_cnt_q, check_cnt_d;
    logic [1:0]  save_cnt_q, save_cnt_d;
    logic [31:0] lock_cnt_q, lock_cnt_d;
    logic [2:0]  fail_next;

    always_comb begin
        state_d     = state_q;
        passinput_d = passinput_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        pass_set_d  = pass_set_q;
        pass_reg_d  = 1'b0;
        pass_lock_d = 1'b0;
        check_cnt_d = check_cnt_q;
        save_cnt_d  = save_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        fail_next   = (fail_cnt_q < MAX_FAIL) ? fail_cnt_q + 3'd1 : fail_cnt_q;

        case (state_q)
            ST_ENTRY, ST_NEWPASS: begin
                if (state_q == ST_NEWPASS && lock_req) begin
                    pass_lock_d = 1'b1;
                    passinput_d = '0;
                    digit_cnt_d = '0;
                    state_d     = ST_ENTRY;
                end else if (clear) begin
                    passinput_d = '0;
                    digit_cnt_d = '0;
                end else if (digit_valid) begin
                    // A fifth digit is dropped; an enter in the same cycle is too.
                    if (digit_cnt_q < 3'd4) begin
                        passinput_d = {passinput_q[11:0], digit};
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end else if (enter && digit_cnt_q == 3'd4) begin
                    if (state_q == ST_ENTRY) begin
                        state_d     = ST_CHECK;
                        pass_set_d  = set_req;
                        check_cnt_d = 1'b0;
                    end else begin
                        state_d    = ST_SAVE;
                        pass_reg_d = 1'b1;
                        save_cnt_d = '0;
                    end
                end
            end
            ST_CHECK: begin
                // The safe registers its verdict one cycle after seeing the code.
                if (!check_cnt_q) begin
                    check_cnt_d = 1'b1;
                end else begin
                    pass_set_d = 1'b0;
                    case (safestate)
                        2'b01: begin
                            state_d    = ST_OPEN;
                            fail_cnt_d = '0;
                        end
                        2'b10: begin
                            state_d     = ST_NEWPASS;
                            fail_cnt_d  = '0;
                            passinput_d = '0;
                            digit_cnt_d = '0;
                        end
                        default: begin
                            fail_cnt_d  = fail_next;
                            passinput_d = '0;
                            digit_cnt_d = '0;
                            if (fail_next == MAX_FAIL) begin
                                state_d    = ST_LOCKOUT;
                                lock_cnt_d = LOCK_LOAD;
                            end else begin
                                state_d = ST_ENTRY;
                            end
                        end
                    endcase
                end
            end
            ST_OPEN: begin
                if (lock_req) begin
                    passinput_d = '0;
                    digit_cnt_d = '0;
                    state_d     = ST_ENTRY;
                end
            end
            ST_SAVE: begin
                if (safestate == 2'b11 || save_cnt_q == 2'd3) begin
                    pass_lock_d = 1'b1;
                    passinput_d = '0;
                    digit_cnt_d = '0;
                    state_d     = ST_ENTRY;
                end else begin
                    save_cnt_d = save_cnt_q + 2'd1;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    fail_cnt_d = '0;
                    state_d    = ST_ENTRY;
                end else begin
                    lock_cnt_d = lock_cnt_q - 32'd1;
                end
            end
            default: state_d = ST_ENTRY;
        endcase

        lockout_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTRY;
            passinput_q <= '0;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
            pass_set_q  <= 1'b0;
            pass_reg_q  <= 1'b0;
            pass_lock_q <= 1'b0;
            lockout_q   <= 1'b0;
            check_cnt_q <= 1'b0;
            save_cnt_q  <= '0;
            lock_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            passinput_q <= passinput_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            pass_set_q  <= pass_set_d;
            pass_reg_q  <= pass_reg_d;
            pass_lock_q <= pass_lock_d;
            lockout_q   <= lockout_d;
            check_cnt_q <= check_cnt_d;
            save_cnt_q  <= save_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    assign passinput  = passinput_q;
    assign pass_set   = pass_set_q;
    assign pass_reg   = pass_reg_q;
    assign pass_lock  = pass_lock_q;
    assign digit_cnt  = digit_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign lockout    = lockout_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_safe_entry_ctrl.sv
// Bench for safe_entry_ctrl with a behavioural safe core holding a password
// (initially 1234) and an 8-cycle lockout.
module tb_safe_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = '0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        set_req = 1'b0;
    logic        lock_req = 1'b0;
    logic [1:0]  safestate = 2'b00;
    logic [15:0] passinput;
    logic        pass_set, pass_reg, pass_lock, lockout;
    logic [2:0]  digit_cnt, fail_cnt, ctrl_state;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_code = 16'h1234;
    logic [15:0] exp_v;
    logic [15:0] safe_pw = 16'h1234;
    logic        force_stuck = 1'b0;

    safe_entry_ctrl #(.MAX_TRIES(3), .LOCKOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .enter(enter), .clear(clear), .set_req(set_req), .lock_req(lock_req),
        .safestate(safestate), .passinput(passinput), .pass_set(pass_set),
        .pass_reg(pass_reg), .pass_lock(pass_lock), .digit_cnt(digit_cnt),
        .fail_cnt(fail_cnt), .lockout(lockout), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    // Safe core: registers its verdict one cycle after seeing code/strobes.
    always @(posedge clk) begin
        if (force_stuck) safestate <= 2'b10;
        else if (pass_reg) begin
            safe_pw   <= passinput;
            safestate <= 2'b11;
        end else if (passinput == safe_pw) safestate <= pass_set ? 2'b10 : 2'b01;
        else safestate <= 2'b00;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic submit(input logic [15:0] code, input logic [2:0] exp_st);
        for (int i = 3; i >= 0; i--) press_digit(code[i*4 +: 4]);
        exp_q.push_back(16'(exp_st));
        enter = 1'b1;
        step();
        enter = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (ctrl_state !== 3'd1 || pass_set !== set_req || passinput !== code) begin
                bad++;
                $display("FAIL check_phase%0d got st=%0d set=%b pi=%h want st=1 set=%b pi=%h",
                         c, ctrl_state, pass_set, passinput, set_req, code);
            end
            step();
        end
        exp_v = exp_q.pop_front();
        total++;
        if (ctrl_state !== exp_v[2:0] || pass_set !== 1'b0) begin
            bad++;
            $display("FAIL decision got st=%0d set=%b want st=%0d set=0", ctrl_state, pass_set, exp_v[2:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({ctrl_state, passinput, digit_cnt, fail_cnt, pass_set, pass_reg, pass_lock, lockout} !== 29'd0) begin
            bad++;
            $display("FAIL reset st=%0d pi=%h dc=%0d fc=%0d set=%b reg=%b lck=%b lo=%b want all 0",
                     ctrl_state, passinput, digit_cnt, fail_cnt, pass_set, pass_reg, pass_lock, lockout);
        end
    endtask

    task automatic test_open();
        submit(16'h1234, 3'd2);
        total++;
        if (passinput !== 16'h1234) begin
            bad++;
            $display("FAIL open_hold got %h want 1234", passinput);
        end
        lock_req = 1'b1;
        step();
        lock_req = 1'b0;
        total++;
        if (ctrl_state !== 3'd0 || passinput !== 16'h0 || digit_cnt !== 3'd0) begin
            bad++;
            $display("FAIL open_lock got st=%0d pi=%h dc=%0d want 0 0000 0", ctrl_state, passinput, digit_cnt);
        end
    endtask

    task automatic test_digit_edges();
        for (int i = 1; i <= 4; i++) press_digit(4'(i));
        press_digit(4'h9);
        total++;
        if (passinput !== 16'h1234 || digit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL fifth_digit got pi=%h dc=%0d want 1234 4", passinput, digit_cnt);
        end
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 1; i <= 3; i++) press_digit(4'(i));
        enter = 1'b1; step(); enter = 1'b0;
        total++;
        if (ctrl_state !== 3'd0 || digit_cnt !== 3'd3) begin
            bad++;
            $display("FAIL enter_short got st=%0d dc=%0d want 0 3", ctrl_state, digit_cnt);
        end
        clear = 1'b1; digit_valid = 1'b1; digit = 4'h7;
        step();
        clear = 1'b0; digit_valid = 1'b0;
        total++;
        if (digit_cnt !== 3'd0 || passinput !== 16'h0) begin
            bad++;
            $display("FAIL clear_vs_digit got dc=%0d pi=%h want 0 0000", digit_cnt, passinput);
        end
        for (int i = 1; i <= 3; i++) press_digit(4'(i));
        digit_valid = 1'b1; digit = 4'h4; enter = 1'b1;
        step();
        digit_valid = 1'b0; enter = 1'b0;
        step();
        total++;
        if (digit_cnt !== 3'd4 || ctrl_state !== 3'd0 || passinput !== 16'h1234) begin
            bad++;
            $display("FAIL digit_vs_enter got dc=%0d st=%0d pi=%h want 4 0 1234", digit_cnt, ctrl_state, passinput);
        end
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic test_lockout();
        for (int t = 1; t <= 3; t++) begin
            submit(16'h1235, (t == 3) ? 3'd5 : 3'd0);
            total++;
            if (fail_cnt !== 3'(t) || lockout !== (t == 3) || digit_cnt !== 3'd0) begin
                bad++;
                $display("FAIL fail_step%0d got fc=%0d lo=%b dc=%0d want %0d %b 0", t, fail_cnt, lockout, digit_cnt, t, t == 3);
            end
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (lockout !== 1'b1 || digit_cnt !== 3'd0 || ctrl_state !== 3'd5) begin
                bad++;
                $display("FAIL lockout_cycle%0d got lo=%b dc=%0d st=%0d want 1 0 5", i, lockout, digit_cnt, ctrl_state);
            end
            digit_valid = 1'b1; digit = 4'(i); enter = 1'b1; clear = 1'b1;
            step();
        end
        digit_valid = 1'b0; enter = 1'b0; clear = 1'b0;
        total++;
        if (lockout !== 1'b0 || ctrl_state !== 3'd0 || fail_cnt !== 3'd0 || digit_cnt !== 3'd0) begin
            bad++;
            $display("FAIL lockout_end got lo=%b st=%0d fc=%0d dc=%0d want 0 0 0 0", lockout, ctrl_state, fail_cnt, digit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) press_digit(4'(i));
        enter = 1'b1; step(); enter = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        total++;
        if ({ctrl_state, passinput, digit_cnt, fail_cnt, pass_set, pass_reg, pass_lock, lockout} !== 29'd0) begin
            bad++;
            $display("FAIL rst_mid_check st=%0d pi=%h dc=%0d set=%b", ctrl_state, passinput, digit_cnt, pass_set);
        end
        for (int t = 1; t <= 3; t++) submit(16'h9999, (t == 3) ? 3'd5 : 3'd0);
        step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        total++;
        if ({ctrl_state, passinput, digit_cnt, fail_cnt, pass_set, pass_reg, pass_lock, lockout} !== 29'd0) begin
            bad++;
            $display("FAIL rst_mid_lockout st=%0d fc=%0d lo=%b want 0 0 0", ctrl_state, fail_cnt, lockout);
        end
        step();
        total++;
        if (ctrl_state !== 3'd0 || lockout !== 1'b0) begin
            bad++;
            $display("FAIL rst_stays_entry got st=%0d lo=%b want 0 0", ctrl_state, lockout);
        end
    endtask

    task automatic test_set_password();
        int locks;
        int overlap;
        set_req = 1'b1;
        submit(cur_code, 3'd3);
        set_req = 1'b0;
        for (int i = 10; i <= 13; i++) press_digit(4'(i));
        exp_q.push_back(16'hABCD);
        enter = 1'b1; step(); enter = 1'b0;
        exp_v = exp_q.pop_front();
        total++;
        if (pass_reg !== 1'b1 || passinput !== exp_v || ctrl_state !== 3'd4) begin
            bad++;
            $display("FAIL pass_reg got reg=%b pi=%h st=%0d want 1 %h 4", pass_reg, passinput, ctrl_state, exp_v);
        end
        locks = 0;
        overlap = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pass_lock) locks++;
            if (pass_lock && pass_reg) overlap++;
        end
        total++;
        if (locks != 1 || overlap != 0 || ctrl_state !== 3'd0 || safe_pw !== 16'hABCD) begin
            bad++;
            $display("FAIL save_flow got locks=%0d overlap=%0d st=%0d want 1 0 0", locks, overlap, ctrl_state);
        end
        cur_code = 16'hABCD;
        submit(cur_code, 3'd2);
        lock_req = 1'b1; step(); lock_req = 1'b0;
    endtask

    task automatic test_watchdog();
        set_req = 1'b1;
        submit(cur_code, 3'd3);
        set_req = 1'b0;
        force_stuck = 1'b1;
        for (int i = 5; i <= 8; i++) press_digit(4'(i));
        enter = 1'b1; step(); enter = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ctrl_state !== 3'd4 || pass_lock !== 1'b0) begin
                bad++;
                $display("FAIL save_wait%0d got st=%0d lck=%b want 4 0", i, ctrl_state, pass_lock);
            end
            step();
        end
        total++;
        if (ctrl_state !== 3'd0 || pass_lock !== 1'b1) begin
            bad++;
            $display("FAIL watchdog got st=%0d lck=%b want 0 1", ctrl_state, pass_lock);
        end
        step();
        force_stuck = 1'b0;
        total++;
        if (pass_lock !== 1'b0) begin
            bad++;
            $display("FAIL lock_width got lck=%b want 0", pass_lock);
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_digit_edges();
        test_lockout();
        test_reset_mid();
        test_set_password();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
